// File: rtl/ks_pkg.sv
// Shared types and constants for the Karplus-Strong pluck exciter.
package ks_pkg;

  typedef enum logic {IDLE = 1'b0, BURST = 1'b1} state_e;

  localparam int          LFSR_W     = 24;
  localparam logic [23:0] LFSR_TAPS  = 24'hE10000;  // x^24+x^23+x^22+x^17+1, right-shifting Galois form
  localparam int          DATA_W_DEF = 16;

endpackage

// File: rtl/ks_lfsr_noise.sv
// 24-bit Galois LFSR noise source; advances on step, reloads seed if it ever reaches zero.
// Latency: value updates on the clk after step. No backpressure.
module ks_lfsr_noise
  import ks_pkg::*;
(
  input  logic              clk,
  input  logic              reset_n,
  input  logic              step,
  input  logic [LFSR_W-1:0] seed,
  output logic [LFSR_W-1:0] value
);

  logic [LFSR_W-1:0] lfsr_q, lfsr_d;

  always_comb begin
    lfsr_d = lfsr_q;
    if (lfsr_q == '0) begin
      lfsr_d = seed;
    end else if (step) begin
      lfsr_d = {1'b0, lfsr_q[LFSR_W-1:1]} ^ (lfsr_q[0] ? LFSR_TAPS : '0);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) lfsr_q <= seed;
    else          lfsr_q <= lfsr_d;
  end

  assign value = lfsr_q;

endmodule

// File: rtl/ks_pluck_exciter.sv
// Noise-burst exciter for the KS string: trigger edge starts burst_len samples, one per ena.
// Latency: q registered, updates the clk after ena. Optional decay envelope: PLUCK_ENVELOPE_EN.
module ks_pluck_exciter
  import ks_pkg::*;
#(
  parameter int                datawidth = DATA_W_DEF,
  parameter int                lenbits   = 12,
  parameter logic [LFSR_W-1:0] seed      = 24'h5A5A5A,
  parameter int                decaybits = 6
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 ena,
  input  logic                 trigger,
  input  logic [lenbits-1:0]   burst_len,
  input  logic [3:0]           level,
  output logic [datawidth-1:0] q,
  output logic                 busy
);

  state_e               state_q, state_d;
  logic [lenbits-1:0]   count_q, count_d;
  logic [datawidth-1:0] q_q, q_d;
  logic                 trig_d_q, trig_d_d;
  logic                 trig_edge, burst_start, step;
  logic [LFSR_W-1:0]    lfsr_value;
  logic [3:0]           shift;
  logic signed [datawidth-1:0] noise_raw, noise;
  logic                 unused_ok;

  ks_lfsr_noise u_noise (
    .clk     (clk),
    .reset_n (reset_n),
    .step    (step),
    .seed    (seed),
    .value   (lfsr_value)
  );

  assign unused_ok = ^lfsr_value;
  assign noise_raw = lfsr_value[datawidth-1:0];
  assign trig_edge = trigger & ~trig_d_q;

`ifdef PLUCK_ENVELOPE_EN
  logic [3:0]           env_q, env_d;
  logic [decaybits-1:0] pre_q, pre_d;
  logic [4:0]           shift_sum;

  assign shift_sum = {1'b0, level} + {1'b0, env_q};
  assign shift     = shift_sum[4] ? 4'd15 : shift_sum[3:0];

  // Prescaler counts emitted samples; env steps once per full prescaler wrap.
  always_comb begin
    env_d = env_q;
    pre_d = pre_q;
    if (burst_start) begin
      env_d = '0;
      pre_d = '0;
    end else if (step) begin
      pre_d = pre_q + 1'b1;
      if (&pre_q && env_q != 4'd15) env_d = env_q + 4'd1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      env_q <= '0;
      pre_q <= '0;
    end else begin
      env_q <= env_d;
      pre_q <= pre_d;
    end
  end
`else
  logic [31:0] unused_decay;
  assign unused_decay = decaybits;
  assign shift        = level;
`endif

  assign noise = noise_raw >>> shift;

  // A trigger edge always takes priority over a coincident ena, so that cycle emits nothing.
  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    q_d         = q_q;
    trig_d_d    = trigger;
    burst_start = 1'b0;
    step        = 1'b0;
    case (state_q)
      IDLE: begin
        if (trig_edge && burst_len != '0) begin
          state_d     = BURST;
          count_d     = burst_len;
          burst_start = 1'b1;
        end
      end
      BURST: begin
        if (trig_edge) begin
          count_d     = burst_len;
          burst_start = 1'b1;
        end else if (ena) begin
          if (count_q != '0) begin
            q_d     = noise;
            count_d = count_q - 1'b1;
            step    = 1'b1;
          end else begin
            q_d     = '0;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      count_q  <= '0;
      q_q      <= '0;
      trig_d_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      q_q      <= q_d;
      trig_d_q <= trig_d_d;
    end
  end

  assign q    = q_q;
  assign busy = (state_q == BURST);

endmodule
